// File: rtl/bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// bus_cycle_ctrl
//   Cycle controller for a 65C816 system. Derives PHI2 from clk, latches the
//   bank byte multiplexed on the data bus at the PHI2 rising edge, decodes the
//   full 24-bit address into prioritised active-low chip selects, and stretches
//   the PHI2 high phase by a per-region number of wait states.
//
// Ports
//   clk        in   system clock (only clock in the block)
//   resb       in   asynchronous active-low reset
//   ab         in   CPU address bus [15:0]
//   db_in      in   CPU data bus input, carries the bank byte while PHI2 low
//   vpa, vda   in   CPU valid program / data address
//   rwb        in   CPU read(1) / write(0)
//   phi2       out  generated CPU clock
//   bank       out  latched bank byte
//   addr24     out  {bank, latched ab}, stable for the whole high phase
//   cs_n       out  active-low region selects [NUM_REGIONS-1:0], at most one low
//   rd_n       out  active-low read strobe
//   wr_n       out  active-low write strobe
//   db_oe      out  drive the CPU data bus (read from a mapped region)
//   ws_active  out  PHI2 high phase is currently being stretched
//   unmapped   out  valid cycle that hit no region, for the whole high phase
//   dbg_state  out  current FSM state (LO=0, HI=1, WAIT=2)
// ---------------------------------------------------------------------------
module bus_cycle_ctrl #(
    parameter int                          HALF_DIV    = 2,
    parameter int                          NUM_REGIONS = 4,
    parameter logic [24*NUM_REGIONS-1:0]   REGION_BASE = {24'h010000, 24'h00C000, 24'h008000, 24'h000000},
    parameter logic [24*NUM_REGIONS-1:0]   REGION_MASK = {24'hFF0000, 24'hFFC000, 24'hFFFFF0, 24'hFF8000},
    parameter logic [4*NUM_REGIONS-1:0]    REGION_WS   = {4'd0, 4'd1, 4'd2, 4'd0}
) (
    input  logic                   clk,
    input  logic                   resb,
    input  logic [15:0]            ab,
    input  logic [7:0]             db_in,
    input  logic                   vpa,
    input  logic                   vda,
    input  logic                   rwb,
    output logic                   phi2,
    output logic [7:0]             bank,
    output logic [23:0]            addr24,
    output logic [NUM_REGIONS-1:0] cs_n,
    output logic                   rd_n,
    output logic                   wr_n,
    output logic                   db_oe,
    output logic                   ws_active,
    output logic                   unmapped,
    output logic [1:0]             dbg_state
);

    // Counter must cover the longest stretch: 15 wait states of HALF_DIV clks.
    localparam int CNT_W = $clog2(HALF_DIV * 16 + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    localparam logic [1:0] ST_LO   = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_wait_last;
    logic                   r_has_ws;
    logic                   r_phi2;
    logic [7:0]             r_bank;
    logic [23:0]            r_addr24;
    logic [NUM_REGIONS-1:0] r_cs_n;
    logic                   r_rd_n;
    logic                   r_wr_n;
    logic                   r_db_oe;
    logic                   r_ws_active;
    logic                   r_unmapped;

    logic [23:0]            w_addr;
    logic                   w_valid;
    logic                   w_hit;
    logic [3:0]             w_hit_ws;
    logic [NUM_REGIONS-1:0] w_cs_n;
    logic [CNT_W-1:0]       w_wait_last;
    logic                   w_end;

    // Region decode of the address presented during PHI2 low. Scanning from the
    // highest index down lets the lowest matching index overwrite, so it wins.
    always_comb begin
        w_addr   = {db_in, ab};
        w_valid  = vpa | vda;
        w_hit    = 1'b0;
        w_hit_ws = 4'd0;
        w_cs_n   = '1;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((w_addr & REGION_MASK[24*i +: 24]) == REGION_BASE[24*i +: 24]) begin
                w_hit     = 1'b1;
                w_hit_ws  = REGION_WS[4*i +: 4];
                w_cs_n    = '1;
                w_cs_n[i] = 1'b0;
            end
        end
        // Last count value of the WAIT phase; meaningless when no wait states.
        w_wait_last = CNT_W'(int'(w_hit_ws) * HALF_DIV - 1);
    end

    // High phase (HI, optionally followed by WAIT) finishes on this edge.
    always_comb begin
        w_end = 1'b0;
        if (r_state == ST_HI && r_cnt == HALF_LAST && !r_has_ws)
            w_end = 1'b1;
        if (r_state == ST_WAIT && r_cnt == r_wait_last)
            w_end = 1'b1;
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            r_state     <= ST_LO;
            r_cnt       <= '0;
            r_wait_last <= '0;
            r_has_ws    <= 1'b0;
            r_phi2      <= 1'b0;
            r_bank      <= 8'h00;
            r_addr24    <= 24'h000000;
            r_cs_n      <= '1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_db_oe     <= 1'b0;
            r_ws_active <= 1'b0;
            r_unmapped  <= 1'b0;
        end else if (w_end) begin
            // Every strobe drops together with PHI2 on one edge.
            r_state     <= ST_LO;
            r_cnt       <= '0;
            r_phi2      <= 1'b0;
            r_cs_n      <= '1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_db_oe     <= 1'b0;
            r_ws_active <= 1'b0;
            r_unmapped  <= 1'b0;
        end else begin
            case (r_state)
                ST_LO: begin
                    if (r_cnt == HALF_LAST) begin
                        // Sampling edge: the only point where CPU inputs matter.
                        r_state     <= ST_HI;
                        r_cnt       <= '0;
                        r_phi2      <= 1'b1;
                        r_bank      <= db_in;
                        r_addr24    <= w_addr;
                        r_wait_last <= w_wait_last;
                        r_has_ws    <= w_valid && w_hit && (w_hit_ws != 4'd0);
                        r_unmapped  <= w_valid && !w_hit;
                        if (w_valid && w_hit) begin
                            r_cs_n  <= w_cs_n;
                            r_rd_n  <= ~rwb;
                            r_wr_n  <= rwb;
                            r_db_oe <= rwb;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (r_cnt == HALF_LAST) begin
                        // Only reached with wait states pending (else w_end).
                        r_state     <= ST_WAIT;
                        r_cnt       <= '0;
                        r_ws_active <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_state <= ST_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign phi2      = r_phi2;
    assign bank      = r_bank;
    assign addr24    = r_addr24;
    assign cs_n      = r_cs_n;
    assign rd_n      = r_rd_n;
    assign wr_n      = r_wr_n;
    assign db_oe     = r_db_oe;
    assign ws_active = r_ws_active;
    assign unmapped  = r_unmapped;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_ctrl
//   Directed bench for bus_cycle_ctrl. A table of bus cycles with hand-computed
//   decode results and phase lengths, plus hand-written sequences for reset
//   values, reset during a stretched cycle, and overlapping-region priority
//   (second instance whose region 2 overlaps region 0).
// ---------------------------------------------------------------------------
module tb_bus_cycle_ctrl;

    localparam int HALF_DIV = 2;

    logic        clk = 1'b0;
    logic        resb;
    logic [15:0] ab;
    logic [7:0]  db_in;
    logic        vpa, vda, rwb;

    logic        phi2, rd_n, wr_n, db_oe, ws_active, unmapped;
    logic [7:0]  bank;
    logic [23:0] addr24;
    logic [3:0]  cs_n;
    logic [1:0]  dbg_state;

    logic        o_phi2, o_rd_n, o_wr_n, o_db_oe, o_ws_active, o_unmapped;
    logic [7:0]  o_bank;
    logic [23:0] o_addr24;
    logic [3:0]  o_cs_n;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;
    int rd_edges = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [15:0] ab;
        logic [7:0]  db;
        logic        vpa;
        logic        vda;
        logic        rwb;
        logic [3:0]  cs_n;
        logic        rd_n;
        logic        wr_n;
        logic        oe;
        logic        unm;
        int          hi;
        int          ws;
    } vec_t;

    vec_t vecs[12];
    vec_t ovl_vec;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(rd_n) if (mon_en) rd_edges++;

    // ---------------- DUTs ----------------
    bus_cycle_ctrl #(.HALF_DIV(HALF_DIV)) u_dut (
        .clk(clk), .resb(resb), .ab(ab), .db_in(db_in), .vpa(vpa), .vda(vda),
        .rwb(rwb), .phi2(phi2), .bank(bank), .addr24(addr24), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n), .db_oe(db_oe), .ws_active(ws_active),
        .unmapped(unmapped), .dbg_state(dbg_state)
    );

    // Region 2 moved onto bank 0 page 0 so it overlaps region 0.
    bus_cycle_ctrl #(
        .HALF_DIV(HALF_DIV),
        .REGION_BASE({24'h010000, 24'h000000, 24'h008000, 24'h000000})
    ) u_ovl (
        .clk(clk), .resb(resb), .ab(ab), .db_in(db_in), .vpa(vpa), .vda(vda),
        .rwb(rwb), .phi2(o_phi2), .bank(o_bank), .addr24(o_addr24), .cs_n(o_cs_n),
        .rd_n(o_rd_n), .wr_n(o_wr_n), .db_oe(o_db_oe), .ws_active(o_ws_active),
        .unmapped(o_unmapped), .dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one bus cycle. Entered on a negedge with PHI2 low at the start of LO.
    task automatic run_vec(input int id, input vec_t v, input bit chk_ovl);
        int          lo;
        int          hi;
        int          wsn;
        bit          held;
        logic [23:0] ea;
        ea    = {v.db, v.ab};
        ab    = v.ab;
        db_in = v.db;
        vpa   = v.vpa;
        vda   = v.vda;
        rwb   = v.rwb;
        lo = 0;
        while (phi2 === 1'b0 && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        chk($sformatf("v%0d lo_len", id), lo, HALF_DIV);
        if (phi2 !== 1'b1) return;
        chk($sformatf("v%0d addr24", id), addr24, ea);
        chk($sformatf("v%0d bank", id), bank, v.db);
        chk($sformatf("v%0d cs_n", id), cs_n, v.cs_n);
        chk($sformatf("v%0d rd_n", id), rd_n, v.rd_n);
        chk($sformatf("v%0d wr_n", id), wr_n, v.wr_n);
        chk($sformatf("v%0d db_oe", id), db_oe, v.oe);
        chk($sformatf("v%0d unmapped", id), unmapped, v.unm);
        chk($sformatf("v%0d ws_first", id), ws_active, 1'b0);
        if (chk_ovl) chk($sformatf("v%0d ovl_cs_n", id), o_cs_n, 4'b1110);
        // Inputs change during the high phase; outputs must not follow.
        ab    = ~v.ab;
        db_in = ~v.db;
        rwb   = ~v.rwb;
        vpa   = ~v.vpa;
        vda   = ~v.vda;
        hi = 0;
        wsn = 0;
        held = 1'b1;
        while (phi2 === 1'b1 && hi < 40) begin
            hi++;
            if (ws_active === 1'b1) wsn++;
            if (cs_n !== v.cs_n || rd_n !== v.rd_n || wr_n !== v.wr_n ||
                db_oe !== v.oe || unmapped !== v.unm || addr24 !== ea || bank !== v.db)
                held = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("v%0d hi_len", id), hi, v.hi);
        chk($sformatf("v%0d ws_len", id), wsn, v.ws);
        chk($sformatf("v%0d held", id), held, 1'b1);
        chk($sformatf("v%0d idle", id), {cs_n, rd_n, wr_n, db_oe, ws_active, unmapped},
            {4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main test ----------------
    initial begin
        int n;
        //            ab        db     vpa   vda   rwb   cs_n     rd    wr    oe    unm  hi ws
        vecs[0]  = '{16'h1234, 8'h00, 1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0};
        vecs[1]  = '{16'h8003, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 6, 4};
        vecs[2]  = '{16'hC000, 8'h00, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b0, 4, 2};
        vecs[3]  = '{16'hC000, 8'h01, 1'b1, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0};
        vecs[4]  = '{16'h9000, 8'h00, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0};
        vecs[5]  = '{16'h9000, 8'h00, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0};
        vecs[6]  = '{16'hFFFF, 8'hFF, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0};
        vecs[7]  = '{16'h800F, 8'h00, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0, 6, 4};
        vecs[8]  = '{16'h8010, 8'h00, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0};
        vecs[9]  = '{16'h7FFF, 8'h00, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[10] = '{16'hFFFF, 8'h01, 1'b1, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0};
        vecs[11] = '{16'h0000, 8'h02, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0};
        ovl_vec  = '{16'h0100, 8'h00, 1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0};

        // Reset with busy-looking inputs applied.
        resb  = 1'b0;
        ab    = 16'h1234;
        db_in = 8'h55;
        vpa   = 1'b1;
        vda   = 1'b1;
        rwb   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst phi2", phi2, 1'b0);
        chk("rst bank", bank, 8'h00);
        chk("rst addr24", addr24, 24'h000000);
        chk("rst cs_n", cs_n, 4'hF);
        chk("rst rd_wr", {rd_n, wr_n}, 2'b11);
        chk("rst db_oe", db_oe, 1'b0);
        chk("rst ws_active", ws_active, 1'b0);
        chk("rst unmapped", unmapped, 1'b0);
        chk("rst state", dbg_state, 2'd0);

        // Release on a negedge; the first vector also measures the rise delay.
        resb = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i], 1'b0);

        // Reset asserted in the middle of the WAIT phase of an ACIA write.
        ab    = 16'h8003;
        db_in = 8'h00;
        vpa   = 1'b0;
        vda   = 1'b1;
        rwb   = 1'b0;
        n = 0;
        while (ws_active !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midrst reached_wait", ws_active, 1'b1);
        @(negedge clk);
        chk("midrst pre_wr_n", wr_n, 1'b0);
        chk("midrst pre_cs_n", cs_n, 4'b1101);
        rd_edges = 0;
        mon_en   = 1'b1;
        resb     = 1'b0;
        #1;
        chk("midrst phi2", phi2, 1'b0);
        chk("midrst cs_n", cs_n, 4'hF);
        chk("midrst wr_n", wr_n, 1'b1);
        chk("midrst rd_n", rd_n, 1'b1);
        chk("midrst ws_active", ws_active, 1'b0);
        chk("midrst state", dbg_state, 2'd0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("midrst rd_n_glitch", rd_edges, 0);

        // Release both instances together: rise delay after reset, and priority
        // between overlapping regions 0 and 2 on the second instance.
        resb = 1'b1;
        run_vec(100, ovl_vec, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
